// File: rtl/rv32ima_pkg.sv
// ============================================================================
// Module : rv32ima_pkg
// Brief  : Shared types for the rv32ima memory subsystem (widths, arbiter FSM,
//          captured bus request).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rv32ima_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_width_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        IGRANT = 2'b01,
        DGRANT = 2'b10
    } mem_arb_state_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            wen;
        logic [XLEN-1:0] wdata;
        mem_width_t      width;
    } mem_req_t;

    // The reserved encoding 2'b11 is folded onto a full-word access.
    function automatic mem_width_t norm_width(input logic [1:0] w);
        mem_width_t r;
        case (w)
            2'b00:   r = BYTE;
            2'b01:   r = HALF;
            default: r = WORD;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bus_if.sv
// ============================================================================
// Module : mem_bus_if
// Brief  : Unified memory bus bundle between the arbiter (master) and memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_bus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        width;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wen, addr, wdata, width,
        input  ready, rdata
    );

    modport slave (
        input  req, wen, addr, wdata, width,
        output ready, rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module : mem_arbiter
// Brief  : Arbitrates instruction-fetch and data ports onto one memory bus,
//          data first, with a streak limit that guarantees fetch progress.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import rv32ima_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              imem_ren,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic              ihit,
    output logic [DATA_W-1:0] imem_load,
    input  logic              dmem_ren,
    input  logic              dmem_wen,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_store,
    input  logic [1:0]        dmem_width,
    output logic              dhit,
    output logic [DATA_W-1:0] dmem_load,
    output logic              bus_req,
    output logic              bus_wen,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [1:0]        bus_width,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam logic [3:0] C_MAX_STREAK = 4'(MAX_D_STREAK);

    mem_arb_state_t r_state;
    mem_arb_state_t w_next;
    mem_req_t       r_req;
    logic [3:0]     r_streak;
    logic           w_dreq;
    logic           w_fetch_starved;

    assign w_dreq          = dmem_ren | dmem_wen;
    assign w_fetch_starved = imem_ren && (r_streak == C_MAX_STREAK);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_dreq && !w_fetch_starved) begin
                    w_next = DGRANT;
                end else if (imem_ren) begin
                    w_next = IGRANT;
                end
            end
            IGRANT, DGRANT: begin
                if (bus_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // The bus is driven from this snapshot so requester changes mid-grant are invisible.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_req <= '0;
        end else if (r_state == IDLE) begin
            if (w_next == DGRANT) begin
                r_req.addr  <= XLEN'(dmem_addr);
                r_req.wen   <= dmem_wen;
                r_req.wdata <= XLEN'(dmem_store);
                r_req.width <= norm_width(dmem_width);
            end else if (w_next == IGRANT) begin
                r_req.addr  <= XLEN'(imem_addr);
                r_req.wen   <= 1'b0;
                r_req.wdata <= '0;
                r_req.width <= WORD;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_streak <= '0;
        end else if (bus_ready && (r_state == DGRANT)) begin
            if (!imem_ren) begin
                r_streak <= '0;
            end else if (r_streak != C_MAX_STREAK) begin
                r_streak <= r_streak + 4'd1;
            end
        end else if (bus_ready && (r_state == IGRANT)) begin
            r_streak <= '0;
        end
    end

    // bus_req depends on state only, keeping bus_ready off any path to it.
    always_comb begin
        bus_req   = (r_state != IDLE);
        bus_wen   = r_req.wen;
        bus_addr  = r_req.addr[ADDR_W-1:0];
        bus_wdata = r_req.wdata[DATA_W-1:0];
        bus_width = r_req.width;
        ihit      = 1'b0;
        dhit      = 1'b0;
        imem_load = '0;
        dmem_load = '0;
        if (bus_ready && (r_state == IGRANT)) begin
            ihit      = 1'b1;
            imem_load = bus_rdata;
        end
        if (bus_ready && (r_state == DGRANT)) begin
            dhit = 1'b1;
            if (!r_req.wen) begin
                dmem_load = bus_rdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module : tb_mem_arbiter
// Brief  : Directed self-checking bench for mem_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk;
    logic        nrst;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        ihit;
    logic [31:0] imem_load;
    logic        dmem_ren;
    logic        dmem_wen;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_store;
    logic [1:0]  dmem_width;
    logic        dhit;
    logic [31:0] dmem_load;
    logic        bus_req;
    logic        bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [1:0]  bus_width;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .MAX_D_STREAK (4)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .imem_ren   (imem_ren),
        .imem_addr  (imem_addr),
        .ihit       (ihit),
        .imem_load  (imem_load),
        .dmem_ren   (dmem_ren),
        .dmem_wen   (dmem_wen),
        .dmem_addr  (dmem_addr),
        .dmem_store (dmem_store),
        .dmem_width (dmem_width),
        .dhit       (dhit),
        .dmem_load  (dmem_load),
        .bus_req    (bus_req),
        .bus_wen    (bus_wen),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_width  (bus_width),
        .bus_ready  (bus_ready),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        nrst       = 1'b0;
        imem_ren   = 1'b0;
        imem_addr  = '0;
        dmem_ren   = 1'b0;
        dmem_wen   = 1'b0;
        dmem_addr  = '0;
        dmem_store = '0;
        dmem_width = 2'b10;
        bus_ready  = 1'b0;
        bus_rdata  = '0;
        #3;
        chk("rst_bus_req", 64'(bus_req), 64'd0);
        chk("rst_ihit", 64'(ihit), 64'd0);
        chk("rst_dhit", 64'(dhit), 64'd0);
        tick();
        tick();
        nrst = 1'b1;
        tick();
        chk("rst_streak", 64'(dut.r_streak), 64'd0);

        // Single fetch with ready two cycles after bus_req
        imem_ren  = 1'b1;
        imem_addr = 32'h100;
        #1;
        chk("f_req_c0", 64'(bus_req), 64'd0);
        tick();
        chk("f_req_c1", 64'(bus_req), 64'd1);
        chk("f_addr", 64'(bus_addr), 64'h100);
        chk("f_wen", 64'(bus_wen), 64'd0);
        chk("f_width", 64'(bus_width), 64'd2);
        chk("f_nohit", 64'(ihit), 64'd0);
        tick();
        chk("f_wait", 64'(ihit), 64'd0);
        tick();
        bus_ready = 1'b1;
        bus_rdata = 32'h0000_0013;
        #1;
        chk("f_ihit", 64'(ihit), 64'd1);
        chk("f_load", 64'(imem_load), 64'h13);
        chk("f_dhit", 64'(dhit), 64'd0);
        imem_ren = 1'b0;
        tick();
        bus_ready = 1'b0;
        #1;
        chk("f_ihit_off", 64'(ihit), 64'd0);
        chk("f_load_off", 64'(imem_load), 64'd0);
        chk("f_idle", 64'(bus_req), 64'd0);

        // Simultaneous requests on a zero-wait bus: data first
        bus_ready = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        imem_ren  = 1'b1;
        imem_addr = 32'h104;
        dmem_ren  = 1'b1;
        dmem_addr = 32'h2000;
        tick();
        chk("s_dreq", 64'(bus_req), 64'd1);
        chk("s_daddr", 64'(bus_addr), 64'h2000);
        chk("s_dhit", 64'(dhit), 64'd1);
        chk("s_dload", 64'(dmem_load), 64'hDEADBEEF);
        chk("s_noihit", 64'(ihit), 64'd0);
        dmem_ren = 1'b0;
        tick();
        chk("s_gap_req", 64'(bus_req), 64'd0);
        chk("s_gap_dhit", 64'(dhit), 64'd0);
        tick();
        chk("s_iaddr", 64'(bus_addr), 64'h104);
        chk("s_ihit", 64'(ihit), 64'd1);
        chk("s_iload", 64'(imem_load), 64'hDEADBEEF);
        imem_ren = 1'b0;
        tick();
        chk("s_end_ihit", 64'(ihit), 64'd0);

        // Starvation guard: 4 data grants then the held fetch
        bus_rdata  = 32'h0;
        imem_ren   = 1'b1;
        imem_addr  = 32'h200;
        dmem_wen   = 1'b1;
        dmem_addr  = 32'h3000;
        dmem_store = 32'h55;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("st_dhit", 64'(dhit), 64'd1);
            chk("st_noihit", 64'(ihit), 64'd0);
            tick();
            chk("st_gap", 64'(bus_req), 64'd0);
        end
        chk("st_streak_full", 64'(dut.r_streak), 64'd4);
        tick();
        chk("st_ihit", 64'(ihit), 64'd1);
        chk("st_nodhit", 64'(dhit), 64'd0);
        chk("st_iaddr", 64'(bus_addr), 64'h200);
        tick();
        chk("st_streak_clr", 64'(dut.r_streak), 64'd0);
        imem_ren = 1'b0;
        dmem_wen = 1'b0;
        tick();
        chk("st_idle", 64'(bus_req), 64'd0);

        // Byte write
        bus_ready  = 1'b0;
        dmem_wen   = 1'b1;
        dmem_addr  = 32'h2003;
        dmem_store = 32'hAB;
        dmem_width = 2'b00;
        tick();
        chk("w_wen", 64'(bus_wen), 64'd1);
        chk("w_wdata", 64'(bus_wdata), 64'hAB);
        chk("w_width", 64'(bus_width), 64'd0);
        chk("w_addr", 64'(bus_addr), 64'h2003);
        chk("w_nohit", 64'(dhit), 64'd0);
        bus_ready = 1'b1;
        #1;
        chk("w_dhit", 64'(dhit), 64'd1);
        chk("w_load", 64'(dmem_load), 64'd0);
        dmem_wen = 1'b0;
        tick();
        bus_ready = 1'b0;
        #1;
        chk("w_dhit_off", 64'(dhit), 64'd0);

        // Stall with changing address; ren+wen -> write, width 11 -> word
        dmem_ren   = 1'b1;
        dmem_wen   = 1'b1;
        dmem_addr  = 32'h4000;
        dmem_store = 32'h1122_3344;
        dmem_width = 2'b11;
        tick();
        chk("h_wen", 64'(bus_wen), 64'd1);
        chk("h_width", 64'(bus_width), 64'd2);
        for (int i = 0; i < 5; i++) begin
            dmem_addr = 32'h5000 + 32'(i);
            #1;
            chk("h_addr", 64'(bus_addr), 64'h4000);
            chk("h_nohit", 64'(dhit), 64'd0);
            chk("h_req", 64'(bus_req), 64'd1);
            tick();
        end
        bus_ready = 1'b1;
        #1;
        chk("h_dhit", 64'(dhit), 64'd1);
        chk("h_wdata", 64'(bus_wdata), 64'h11223344);
        dmem_ren = 1'b0;
        dmem_wen = 1'b0;
        tick();
        bus_ready = 1'b0;

        // Reset mid-grant
        dmem_ren   = 1'b1;
        dmem_addr  = 32'h6000;
        dmem_width = 2'b10;
        tick();
        chk("r_req_pre", 64'(bus_req), 64'd1);
        nrst      = 1'b0;
        bus_ready = 1'b1;
        #1;
        chk("r_req_drop", 64'(bus_req), 64'd0);
        chk("r_nodhit", 64'(dhit), 64'd0);
        bus_ready = 1'b0;
        tick();
        nrst = 1'b1;
        #1;
        chk("r_idle", 64'(bus_req), 64'd0);
        tick();
        chk("r_regrant", 64'(bus_req), 64'd1);
        chk("r_addr", 64'(bus_addr), 64'h6000);
        bus_ready = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        #1;
        chk("r_dhit", 64'(dhit), 64'd1);
        chk("r_load", 64'(dmem_load), 64'hCAFEF00D);
        dmem_ren = 1'b0;
        tick();
        bus_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified memory bus between the datapath's instruction-fetch port and data port (von Neumann configuration).
- Accepts held-level requests, grants one requester at a time and forwards its transaction to the bus.
- Returns ihit/dhit plus load data to the datapath.
- Data requests have priority; a streak counter prevents instruction-fetch starvation.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_D_STREAK, 4, max consecutive data grants while a fetch is pending; range 1..15.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- imem_ren  in  1  fetch request; held until ihit
- imem_addr  in  ADDR_W  fetch address
- ihit  out  1  fetch complete; imem_load valid this cycle
- imem_load  out  DATA_W  fetched instruction
- dmem_ren  in  1  data read request; held until dhit
- dmem_wen  in  1  data write request; held until dhit
- dmem_addr  in  ADDR_W  data address
- dmem_store  in  DATA_W  write data
- dmem_width  in  2  00 byte, 01 half, 10 word; 11 treated as word
- dhit  out  1  data transaction complete; dmem_load valid on reads
- dmem_load  out  DATA_W  read data
- bus_req  out  1  transaction valid
- bus_wen  out  1  1 = write
- bus_addr  out  ADDR_W  transaction address
- bus_wdata  out  DATA_W  write data
- bus_width  out  2  access width
- bus_ready  in  1  bus completes the transaction this cycle
- bus_rdata  in  DATA_W  read data; valid when bus_ready

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on nrst.
- States: IDLE, IGRANT, DGRANT.
- Reset values: state IDLE, streak counter 0, captured request registers 0. While nrst is low, bus_req, ihit and dhit are 0.
- IDLE transitions (arbitration):
  - dreq = dmem_ren | dmem_wen.
  - dreq and not (imem_ren and streak == MAX_D_STREAK) -> DGRANT.
  - Else if imem_ren -> IGRANT.
  - Else stay in IDLE.
- Capture on grant: at the granting edge, addr, wen, wdata and width are captured into registers. Bus outputs are driven only from these registers, so requester changes during a grant are ignored.
  - Fetch: wen = 0, width = 10.
  - Data: if ren and wen are both high, the write wins.
- In IGRANT or DGRANT:
  - bus_req = 1.
  - When bus_ready = 1: the corresponding hit is asserted combinationally in the same cycle, load output = bus_rdata, and next state is IDLE.
  - When bus_ready = 0: hold the state; bus outputs are stable.
- Latency:
  - Minimum is 2 cycles: request seen in cycle 0, bus_req in cycle 1, hit in cycle 1 if bus_ready.
  - Back-to-back transactions need one IDLE cycle between them.
- Hit outputs: ihit and dhit are never high together. Each is high for exactly one cycle per transaction. imem_load and dmem_load are 0 when the corresponding hit is 0.
- Streak counter:
  - Increments, saturating at MAX_D_STREAK, on each DGRANT completion while imem_ren = 1.
  - Clears on IGRANT completion, or when a DGRANT completes with imem_ren = 0.
- Dropped request: if a requester drops its request mid-grant (illegal), the transaction still completes and the hit still pulses.
- Reset mid-transaction: bus_req drops immediately (async). The bus must tolerate an abandoned transaction. No hit is issued.
- Other rules: no address-alignment checks. No combinational path from bus_ready to bus_req.

Decomposition:
- rv32ima_pkg gains:
  - mem_width_t (BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10);
  - mem_arb_state_t (IDLE, IGRANT, DGRANT);
  - mem_req_t struct {addr, wen, wdata, width} for the capture register.
- New interface mem_bus_if carries the bus signals, with modports master and slave.
- No sub-module is needed; FSM, streak counter and capture register are implemented in one module.

Test Plan:
- Single fetch: imem_ren = 1, addr 0x100; bus_ready high 2 cycles after bus_req with rdata 0x00000013 -> bus_req with addr 0x100, wen 0, width 10; ihit = 1 for one cycle with imem_load = 0x00000013.
- Simultaneous requests: imem_ren and dmem_ren both high, dmem_addr 0x2000; zero-wait bus -> data transaction granted first and dhit issued, one IDLE cycle, then fetch granted and ihit issued.
- Starvation guard: imem_ren held with dmem_wen continuously high, MAX_D_STREAK = 4 -> exactly 4 dhit pulses, then one ihit, then streak back to 0.
- Write with width: dmem_wen = 1, addr 0x2003, store 0xAB, width 00 -> bus_wen = 1, bus_wdata = 0xAB, bus_width = 00; dhit on bus_ready; dmem_load = 0.
- Stall and stability: bus_ready low for 5 cycles while dmem_addr is changed by the bench -> bus_addr holds the captured value; no hit until bus_ready.
- Reset mid-grant: nrst low during DGRANT -> bus_req = 0 immediately and no dhit. After release, state is IDLE and a held request is re-granted.
